// File: rtl/adc_capture_buffer_if.sv
// AXI4-Stream bundle for the ADC input and the replay output of adc_capture_buffer.
// The master view carries tlast only when ADC_CAPTURE_TLAST_EN is defined.
interface adc_capture_buffer_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
`ifdef ADC_CAPTURE_TLAST_EN
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
`else
  modport master (output tdata, output tvalid, input tready);
`endif
  // The RFDC stream has no framing, so the slave view never includes tlast.
  modport slave (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_capture_buffer.sv
// Single-shot triggered ADC capture: fills 2^DEPTH_LOG2 valid beats into block RAM, then replays them.
// Optional feature macro: ADC_CAPTURE_TLAST_EN adds m_axis.tlast on the final replayed beat.
module adc_capture_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 capture_i,
  adc_capture_buffer_if.slave  s_axis,
  adc_capture_buffer_if.master m_axis,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [7:0]           missed_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_reg, state_next;

  (* ASYNC_REG = "TRUE" *) logic cap_s1;
  (* ASYNC_REG = "TRUE" *) logic cap_s2;
  logic cap_s3;
  logic trigger;
  logic accept;
  logic missed_inc;

  logic [AW-1:0] wr_addr_reg;
  logic [AW-1:0] rd_addr_reg;
  logic          wr_en;
  logic          wr_last;
  logic          rd_en;
  logic          rd_last;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  logic                  pend_reg;
  logic                  pend_last_reg;
  logic                  out_valid_reg;
  logic                  out_last_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  skid_valid_reg;
  logic                  skid_last_reg;
  logic [DATA_WIDTH-1:0] skid_data_reg;
  logic                  pop;
  logic                  out_free;
  logic                  drain_end;
  logic [1:0]            occ_next;

  logic       done_reg;
  logic [7:0] missed_reg;
  logic       s_ready_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cap_s1 <= 1'b0;
      cap_s2 <= 1'b0;
      cap_s3 <= 1'b0;
    end else begin
      cap_s1 <= capture_i;
      cap_s2 <= cap_s1;
      cap_s3 <= cap_s2;
    end
  end

  assign trigger = cap_s2 & ~cap_s3;
  // done_o cycle is still treated as part of the capture, so a trigger there is a miss.
  assign accept     = trigger & (state_reg == IDLE) & ~done_reg;
  assign missed_inc = trigger & ~accept;

  assign wr_en   = (state_reg == FILL) & s_axis.tvalid;
  assign wr_last = (wr_addr_reg[DEPTH_LOG2-1:0] == '1);
  assign rd_last = (rd_addr_reg[DEPTH_LOG2-1:0] == '1);

  assign pop       = out_valid_reg & m_axis.tready;
  assign out_free  = ~out_valid_reg | pop;
  assign drain_end = (state_reg == DRAIN) & pop & out_last_reg;

  // Beats held next cycle if nothing new is read; a read is issued only if it will fit.
  assign occ_next = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg}
                  + {1'b0, pend_reg} - {1'b0, pop};
  assign rd_en    = (state_reg == DRAIN) & ~rd_addr_reg[DEPTH_LOG2] & (occ_next < 2'd2);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = FILL;
      FILL:    if (wr_en && wr_last) state_next = DRAIN;
      DRAIN:   if (drain_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg   <= IDLE;
      wr_addr_reg <= '0;
      rd_addr_reg <= '0;
      done_reg    <= 1'b0;
      missed_reg  <= 8'd0;
      s_ready_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      s_ready_reg <= 1'b1;
      done_reg    <= drain_end;

      if (accept) begin
        wr_addr_reg <= '0;
      end else if (wr_en) begin
        wr_addr_reg <= wr_addr_reg + 1'b1;
      end

      if (state_reg == FILL && state_next == DRAIN) begin
        rd_addr_reg <= '0;
      end else if (rd_en) begin
        rd_addr_reg <= rd_addr_reg + 1'b1;
      end

      if (missed_inc && missed_reg != 8'hFF) begin
        missed_reg <= missed_reg + 8'd1;
      end
    end
  end

  // Capture memory: no reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_addr_reg[DEPTH_LOG2-1:0]] <= s_axis.tdata;
    end
    if (rd_en) begin
      ram_q <= mem[rd_addr_reg[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pend_reg       <= 1'b0;
      pend_last_reg  <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_last_reg  <= 1'b0;
      skid_data_reg  <= '0;
    end else begin
      pend_reg <= rd_en;
      if (rd_en) begin
        pend_last_reg <= rd_last;
      end

      if (out_free) begin
        if (skid_valid_reg) begin
          out_valid_reg  <= 1'b1;
          out_data_reg   <= skid_data_reg;
          out_last_reg   <= skid_last_reg;
          skid_valid_reg <= pend_reg;
          if (pend_reg) begin
            skid_data_reg <= ram_q;
            skid_last_reg <= pend_last_reg;
          end
        end else if (pend_reg) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= ram_q;
          out_last_reg  <= pend_last_reg;
        end else begin
          out_valid_reg <= 1'b0;
          out_last_reg  <= 1'b0;
        end
      end else if (pend_reg) begin
        // Output is stalled: the in-flight read parks in the skid entry.
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= ram_q;
        skid_last_reg  <= pend_last_reg;
      end
    end
  end

  assign s_axis.tready = s_ready_reg;
  assign m_axis.tvalid = out_valid_reg;
  assign m_axis.tdata  = out_data_reg;
`ifdef ADC_CAPTURE_TLAST_EN
  assign m_axis.tlast  = out_last_reg;
`endif

  assign busy_o   = (state_reg != IDLE);
  assign done_o   = done_reg;
  assign missed_o = missed_reg;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Self-checking bench for adc_capture_buffer with DEPTH_LOG2=2: vector table plus corner sequences.
// Build with ADC_CAPTURE_TLAST_EN defined to also check m_axis.tlast.
module tb_adc_capture_buffer;
  localparam int DW = 128;
  localparam int DL = 2;
  localparam int NB = 1 << DL;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       capture_i = 1'b0;
  logic       busy_o;
  logic       done_o;
  logic [7:0] missed_o;

  adc_capture_buffer_if #(.DATA_WIDTH(DW)) s_axis ();
  adc_capture_buffer_if #(.DATA_WIDTH(DW)) m_axis ();

  adc_capture_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(DL)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .capture_i (capture_i),
    .s_axis    (s_axis),
    .m_axis    (m_axis),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .missed_o  (missed_o)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0] vpat;
    logic [7:0] rpat;
    bit         gapless;
    int         exp_hs;
    int         exp_done;
  } vec_t;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] src_cnt = '0;
  logic [DW-1:0] held_data = '0;
  logic [DW-1:0] mon_exp = '0;
  logic          held_valid = 1'b0;
  logic [7:0]    vpat = 8'hFF;
  logic [7:0]    rpat = 8'hFF;
  logic [2:0]    vph = 3'd0;
  logic [2:0]    rph = 3'd0;
  int            arm_wait = 0;
  int            fill_left = 0;
  int            cap_hold = 0;
  int            hs_count = 0;
  int            done_count = 0;
  int            beat_idx = 0;
  int            cyc = 0;
  int            first_hs_cyc = 0;
  int            last_hs_cyc = 0;
  int            done_cyc = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; beats destined for RAM are pushed to the scoreboard here.
  task automatic step();
    logic v;
    if (arm_wait > 0) begin
      v = 1'b1;
    end else begin
      v = vpat[vph];
      vph = vph + 3'd1;
    end
    s_axis.tvalid = v;
    s_axis.tdata  = src_cnt;
    m_axis.tready = rpat[rph];
    rph = rph + 3'd1;
    if (arm_wait > 0) begin
      arm_wait--;
    end else if (fill_left > 0 && v) begin
      exp_q.push_back(src_cnt);
      fill_left--;
    end
    @(posedge aclk);
    #1;
    src_cnt = src_cnt + 1'b1;
    if (cap_hold > 0) begin
      cap_hold--;
      if (cap_hold == 0) capture_i = 1'b0;
    end
  endtask

  // capture_i is first sampled at the next edge N; beats from edge N+3 are stored.
  task automatic start_capture();
    capture_i = 1'b1;
    cap_hold  = 8;
    arm_wait  = 3;
    fill_left = NB;
    vph       = 3'd0;
  endtask

  task automatic pulse();
    capture_i = 1'b1;
    cap_hold  = 4;
    repeat (8) step();
  endtask

  task automatic wait_done();
    int d0;
    int n;
    d0 = done_count;
    n  = 0;
    while (done_count == d0 && n < 200) begin
      step();
      n++;
    end
    total++;
    if (done_count == d0) begin
      bad++;
      $display("FAIL done_timeout: got no done_o expected one within 200 cycles");
    end
    step();
  endtask

  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      held_valid = 1'b0;
      beat_idx   = 0;
    end else begin
      if (held_valid) begin
        check("stall_valid", DW'(m_axis.tvalid), DW'(1));
        check("stall_data", m_axis.tdata, held_data);
      end
      held_valid = 1'b0;
      if (m_axis.tvalid) begin
`ifdef ADC_CAPTURE_TLAST_EN
        check("tlast", DW'(m_axis.tlast), DW'(beat_idx == NB - 1));
`endif
        if (m_axis.tready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got %0h expected no beat", m_axis.tdata);
          end else begin
            mon_exp = exp_q.pop_front();
            check("beat_data", m_axis.tdata, mon_exp);
          end
          $display("beat %0d data=%0h", beat_idx, m_axis.tdata);
          if (beat_idx == 0) first_hs_cyc = cyc;
          if (beat_idx == NB - 1) last_hs_cyc = cyc;
          beat_idx = (beat_idx + 1) % NB;
          hs_count++;
        end else begin
          held_valid = 1'b1;
          held_data  = m_axis.tdata;
        end
      end
      if (done_o) begin
        done_count++;
        done_cyc = cyc;
        check("done_busy_low", DW'(busy_o), DW'(0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    int   hs0;
    int   d0;
    int   exp_missed;

    vecs[0] = '{vpat: 8'hFF, rpat: 8'hFF, gapless: 1'b1, exp_hs: NB, exp_done: 1};
    vecs[1] = '{vpat: 8'hED, rpat: 8'hFF, gapless: 1'b1, exp_hs: NB, exp_done: 1};
    vecs[2] = '{vpat: 8'hFF, rpat: 8'h99, gapless: 1'b0, exp_hs: NB, exp_done: 1};
    vecs[3] = '{vpat: 8'hED, rpat: 8'h99, gapless: 1'b0, exp_hs: NB, exp_done: 1};

    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    m_axis.tready = 1'b0;
`ifdef ADC_CAPTURE_TLAST_EN
    s_axis.tlast  = 1'b0;
`endif

    repeat (2) @(posedge aclk);
    #1;
    check("rst_s_tready", DW'(s_axis.tready), DW'(0));
    check("rst_m_tvalid", DW'(m_axis.tvalid), DW'(0));
    check("rst_m_tdata", m_axis.tdata, DW'(0));
    check("rst_busy", DW'(busy_o), DW'(0));
    check("rst_done", DW'(done_o), DW'(0));
    check("rst_missed", DW'(missed_o), DW'(0));
`ifdef ADC_CAPTURE_TLAST_EN
    check("rst_tlast", DW'(m_axis.tlast), DW'(0));
`endif
    aresetn = 1'b1;
    step();
    check("s_tready_live", DW'(s_axis.tready), DW'(1));

    for (int i = 0; i < 4; i++) begin
      vpat = vecs[i].vpat;
      rpat = vecs[i].rpat;
      hs0  = hs_count;
      d0   = done_count;
      start_capture();
      step();
      step();
      check("busy_before_n2", DW'(busy_o), DW'(0));
      step();
      check("busy_after_n2", DW'(busy_o), DW'(1));
      wait_done();
      check("handshakes", DW'(hs_count - hs0), DW'(vecs[i].exp_hs));
      check("done_pulses", DW'(done_count - d0), DW'(vecs[i].exp_done));
      check("queue_empty", DW'(exp_q.size()), DW'(0));
      check("done_after_last", DW'(done_cyc - last_hs_cyc), DW'(1));
      if (vecs[i].gapless) check("gapless", DW'(last_hs_cyc - first_hs_cyc), DW'(NB - 1));
      check("idle_after", DW'(busy_o), DW'(0));
      $display("vector %0d complete", i);
    end

    // Missed triggers: stall DRAIN with tready low to keep the busy window open.
    vpat = 8'hFF;
    rpat = 8'h00;
    start_capture();
    repeat (10) step();
    for (int p = 0; p < 3; p++) pulse();
    check("missed_3", DW'(missed_o), DW'(3));
    rpat = 8'hFF;
    wait_done();
    check("missed_queue_empty", DW'(exp_q.size()), DW'(0));
    exp_missed = 3;
    for (int w = 0; w < 3; w++) begin
      rpat = 8'h00;
      start_capture();
      repeat (10) step();
      for (int p = 0; p < 100; p++) pulse();
      exp_missed = (exp_missed + 100 > 255) ? 255 : exp_missed + 100;
      check("missed_window", DW'(missed_o), DW'(exp_missed));
      rpat = 8'hFF;
      wait_done();
      check("window_queue_empty", DW'(exp_q.size()), DW'(0));
    end
    check("missed_hold", DW'(missed_o), DW'(255));

    // Reset while beats 2 and 3 are still to be replayed.
    hs0 = hs_count;
    d0  = done_count;
    start_capture();
    for (int n = 0; n < 50 && hs_count < hs0 + 2; n++) step();
    check("mid_drain_reached", DW'(hs_count - hs0), DW'(2));
    aresetn = 1'b0;
    #1;
    check("abort_tvalid", DW'(m_axis.tvalid), DW'(0));
    check("abort_busy", DW'(busy_o), DW'(0));
    check("abort_missed", DW'(missed_o), DW'(0));
    exp_q.delete();
    fill_left = 0;
    arm_wait  = 0;
    cap_hold  = 0;
    capture_i = 1'b0;
    repeat (2) step();
    aresetn = 1'b1;
    repeat (10) step();
    check("abort_no_done", DW'(done_count - d0), DW'(0));
    hs0 = hs_count;
    start_capture();
    wait_done();
    check("fresh_handshakes", DW'(hs_count - hs0), DW'(NB));
    check("fresh_queue_empty", DW'(exp_q.size()), DW'(0));

    // Trigger landing in the done_o cycle: FILL at N0+2, DRAIN N0+6..N0+11, done after N0+12.
    hs0 = hs_count;
    d0  = done_count;
    start_capture();
    repeat (11) step();
    capture_i = 1'b1;
    cap_hold  = 4;
    step();
    step();
    check("done_at_n12", DW'(done_o), DW'(1));
    check("busy_at_n12", DW'(busy_o), DW'(0));
    step();
    check("coincident_not_started", DW'(busy_o), DW'(0));
    repeat (6) step();
    check("coincident_missed", DW'(missed_o), DW'(1));
    check("coincident_idle", DW'(busy_o), DW'(0));
    check("coincident_done_once", DW'(done_count - d0), DW'(1));
    check("coincident_handshakes", DW'(hs_count - hs0), DW'(NB));
    check("coincident_queue_empty", DW'(exp_q.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
